// File: rtl/axis_adc_ddr_capture.sv
// rtl/axis_adc_ddr_capture.sv - multi-channel DDR ADC capture, format, decimate, 2-deep AXIS output FIFO
`timescale 1ns/1ps
module axis_adc_ddr_capture #(
    parameter int DDR_DATA_WIDTH = 7,
    parameter int NUM_CH         = 2,
    parameter int AXIS_CH_WIDTH  = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_CH*DDR_DATA_WIDTH-1:0] adc_dat_in,
    input  logic [15:0]                      cfg_decim,
    input  logic                             cfg_twos_comp,
    input  logic                             cfg_swap_edges,
    output logic [NUM_CH*AXIS_CH_WIDTH-1:0]  m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             sts_overflow,
    output logic [31:0]                      sts_sample_cnt
);
    localparam int ADC_WIDTH = 2 * DDR_DATA_WIDTH;
    localparam int PIN_W     = NUM_CH * DDR_DATA_WIDTH;
    localparam int BEAT_W    = NUM_CH * AXIS_CH_WIDTH;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} fifo_state_e;

    logic [PIN_W-1:0]  rise_q, fall_neg_q, rise_al_q, fall_al_q;
    logic [BEAT_W-1:0] fmt_d, fmt_q;
    logic              fmt_vld_q;
    fifo_state_e       state_q, state_d;
    logic [BEAT_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [15:0]       dcnt_q, dcnt_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              emit, pop;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rise_q    <= '0;
            rise_al_q <= '0;
            fall_al_q <= '0;
        end else begin
            rise_q    <= adc_dat_in;
            rise_al_q <= rise_q;
            fall_al_q <= fall_neg_q;
        end
    end

    // Falling-edge half of each DDR pin; retimed onto posedge above.
    always_ff @(negedge aclk) begin
        if (!aresetn) begin
            fall_neg_q <= '0;
        end else begin
            fall_neg_q <= adc_dat_in;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADC_WIDTH-1:0] raw;
        logic [ADC_WIDTH-1:0] conv;
        for (genvar j = 0; j < DDR_DATA_WIDTH; j++) begin : g_pin
            assign raw[2*j]   = cfg_swap_edges ? fall_al_q[c*DDR_DATA_WIDTH+j]
                                               : rise_al_q[c*DDR_DATA_WIDTH+j];
            assign raw[2*j+1] = cfg_swap_edges ? rise_al_q[c*DDR_DATA_WIDTH+j]
                                               : fall_al_q[c*DDR_DATA_WIDTH+j];
        end
        // Offset-binary to two's complement is an MSB flip.
        assign conv = raw ^ {cfg_twos_comp, {(ADC_WIDTH-1){1'b0}}};
        if (AXIS_CH_WIDTH > ADC_WIDTH) begin : g_ext
            assign fmt_d[c*AXIS_CH_WIDTH +: AXIS_CH_WIDTH] =
                {{(AXIS_CH_WIDTH-ADC_WIDTH){cfg_twos_comp & conv[ADC_WIDTH-1]}}, conv};
        end else begin : g_noext
            assign fmt_d[c*AXIS_CH_WIDTH +: AXIS_CH_WIDTH] = conv;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            fmt_q     <= '0;
            fmt_vld_q <= 1'b0;
        end else begin
            fmt_q     <= fmt_d;
            fmt_vld_q <= 1'b1;
        end
    end

    assign emit = fmt_vld_q && (dcnt_q >= cfg_decim);
    assign pop  = (state_q != ST_EMPTY) && m_axis_tready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        ovf_d   = ovf_q;
        dcnt_d  = dcnt_q;
        cnt_d   = cnt_q + {31'd0, pop};
        if (fmt_vld_q) begin
            dcnt_d = emit ? 16'd0 : dcnt_q + 16'd1;
        end
        case (state_q)
            ST_EMPTY: begin
                if (emit) begin
                    head_d  = fmt_q;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({emit, pop})
                    2'b11: head_d = fmt_q;
                    2'b10: begin
                        tail_d  = fmt_q;
                        state_d = ST_FULL;
                    end
                    2'b01: state_d = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_FULL: begin
                case ({emit, pop})
                    2'b11: begin
                        head_d = tail_q;
                        tail_d = fmt_q;
                    end
                    2'b01: begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                    2'b10: ovf_d = 1'b1;
                    default: ;
                endcase
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            dcnt_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            dcnt_q  <= dcnt_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_axis_tdata   = head_q;
    assign m_axis_tvalid  = (state_q != ST_EMPTY);
    assign sts_overflow   = ovf_q;
    assign sts_sample_cnt = cnt_q;

endmodule

// File: tb/tb_axis_adc_ddr_capture.sv
// tb/tb_axis_adc_ddr_capture.sv - scoreboard bench for axis_adc_ddr_capture
`timescale 1ns/1ps
module tb_axis_adc_ddr_capture;
    localparam int DW   = 7;
    localparam int NC   = 2;
    localparam int AW   = 16;
    localparam int ADCW = 2 * DW;
    localparam int PW   = NC * DW;
    localparam int BW   = NC * AW;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [PW-1:0] adc = '0;
    logic [15:0]   cfg_decim = '0;
    logic          twos = 1'b0;
    logic          swap = 1'b0;
    logic          tready = 1'b0;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          sts_overflow;
    logic [31:0]   sts_sample_cnt;

    axis_adc_ddr_capture #(.DDR_DATA_WIDTH(DW), .NUM_CH(NC), .AXIS_CH_WIDTH(AW)) dut (
        .aclk(clk), .aresetn(aresetn), .adc_dat_in(adc), .cfg_decim(cfg_decim),
        .cfg_twos_comp(twos), .cfg_swap_edges(swap), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(tready),
        .sts_overflow(sts_overflow), .sts_sample_cnt(sts_sample_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each lane is the 14-bit sample built from rise/fall pins; two's complement
    // mode subtracts midscale, and the low 16 bits of the signed result are the lane.
    function automatic logic [BW-1:0] expect_beat(input logic [PW-1:0] r, input logic [PW-1:0] f,
                                                  input logic tw, input logic sw);
        logic [BW-1:0] res = '0;
        for (int c = 0; c < NC; c++) begin
            int raw = 0;
            int s;
            for (int j = 0; j < DW; j++) begin
                raw += int'(sw ? f[c*DW+j] : r[c*DW+j]) << (2*j);
                raw += int'(sw ? r[c*DW+j] : f[c*DW+j]) << (2*j+1);
            end
            s = tw ? raw - (1 << (ADCW-1)) : raw;
            res[c*AW +: AW] = s[AW-1:0];
        end
        return res;
    endfunction

    logic [PW-1:0] rise_h [8];
    logic [PW-1:0] fall_h [8];
    logic          twos_h [8];
    logic          swap_h [8];
    logic          rstn_h [8];
    int            cyc = 0;
    logic [BW-1:0] exp_q [$];
    int            occ = 0;
    logic          ovf_exp = 1'b0;
    int            dcnt_m = 0;
    bit            just_reset = 1'b0;
    int            exp_cnt = 0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            rise_h[i] = '0; fall_h[i] = '0; twos_h[i] = 1'b0; swap_h[i] = 1'b0; rstn_h[i] = 1'b0;
        end
    end

    always @(negedge clk) fall_h[(cyc+7)%8] = adc;

    // Producer: a beat pushed at posedge t comes from pins at t-3, format config at t-1.
    always @(posedge clk) begin : model
        int ic, ib, ip;
        bit pop, emit;
        ic = cyc % 8;
        ib = (cyc + 7) % 8;
        ip = (cyc + 5) % 8;
        rise_h[ic] = adc;
        twos_h[ic] = twos;
        swap_h[ic] = swap;
        rstn_h[ic] = aresetn;
        if (!aresetn) begin
            exp_q.delete();
            occ = 0;
            ovf_exp = 1'b0;
            dcnt_m = 0;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            pop = (occ > 0) && tready;
            emit = 1'b0;
            if (rstn_h[ib]) begin
                if (dcnt_m >= int'(cfg_decim)) begin
                    emit = 1'b1;
                    dcnt_m = 0;
                end else begin
                    dcnt_m++;
                end
            end
            if (emit && occ == 2 && !pop) begin
                ovf_exp = 1'b1;
            end else begin
                if (emit) begin
                    exp_q.push_back(expect_beat(rise_h[ip], fall_h[ip], twos_h[ib], swap_h[ib]));
                    occ++;
                end
                if (pop) occ--;
            end
        end
        cyc++;
    end

    // Monitor: samples just before each posedge, pops the scoreboard on each handshake.
    always begin : monitor
        logic [BW-1:0] e;
        @(negedge clk);
        #4;
        if (!aresetn) begin
            exp_cnt = 0;
        end else begin
            if (just_reset) check("tdata_after_reset", m_axis_tdata, '0);
            check("tvalid", m_axis_tvalid, occ > 0);
            check("overflow", sts_overflow, ovf_exp);
            check("sample_cnt", sts_sample_cnt, exp_cnt);
            if (m_axis_tvalid && tready) begin
                check("scoreboard_has_beat", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tdata", m_axis_tdata, e);
                end
                exp_cnt++;
            end
        end
    end

    task automatic drive(input logic [PW-1:0] r, input logic [PW-1:0] f);
        @(negedge clk);
        #2 adc = r;
        @(posedge clk);
        #2 adc = f;
    endtask

    task automatic drive_samples(input logic [ADCW-1:0] v0, input logic [ADCW-1:0] v1);
        logic [PW-1:0] r, f;
        for (int j = 0; j < DW; j++) begin
            r[j] = v0[2*j];    f[j] = v0[2*j+1];
            r[DW+j] = v1[2*j]; f[DW+j] = v1[2*j+1];
        end
        drive(r, f);
    endtask

    task automatic do_reset();
        repeat (2) drive('0, '0);
        aresetn = 1'b0;
        drive('0, '0);
        aresetn = 1'b1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_overflow", sts_overflow, 1'b0);
        check("rst_sample_cnt", sts_sample_cnt, '0);
        repeat (2) drive('0, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        do_reset();

        twos = 1'b1; swap = 1'b0; cfg_decim = 16'd0; tready = 1'b1;
        for (int v = 0; v < (1 << ADCW); v++) drive_samples(ADCW'(v), ADCW'((1 << ADCW) - 1 - v));
        repeat (6) drive('0, '0);

        twos = 1'b0;
        repeat (10) drive('1, '0);
        swap = 1'b1;
        repeat (10) drive('1, '0);
        swap = 1'b0;

        cfg_decim = 16'd3;
        for (int k = 0; k < 24; k++) drive_samples(ADCW'(k), ADCW'(k + 100));
        w = 0;
        while (dcnt_m != 2 && w < 16) begin
            drive_samples(ADCW'(200 + w), ADCW'(300 + w));
            w++;
        end
        check("decim_sync_bound", w < 16, 1'b1);
        cfg_decim = 16'd1;
        for (int k = 0; k < 12; k++) drive_samples(ADCW'(400 + k), ADCW'(500 + k));
        cfg_decim = 16'd0;

        tready = 1'b0;
        repeat (5) drive_samples(ADCW'($urandom), ADCW'($urandom));
        check("overflow_set", sts_overflow, 1'b1);
        tready = 1'b1;
        repeat (4) drive_samples(ADCW'($urandom), ADCW'($urandom));
        check("overflow_sticky", sts_overflow, 1'b1);

        tready = 1'b0; twos = 1'b1;
        repeat (3) drive('0, '0);
        check("full_before_reset", m_axis_tvalid, 1'b1);
        do_reset();

        cfg_decim = 16'd3; tready = 1'b0;
        w = 0;
        while (!(occ == 2 && dcnt_m == 3) && w < 40) begin
            drive_samples(ADCW'($urandom), ADCW'($urandom));
            w++;
        end
        check("fill_bound", w < 40, 1'b1);
        tready = 1'b1;
        drive_samples(ADCW'($urandom), ADCW'($urandom));
        tready = 1'b0;
        drive('0, '0);
        check("pushpop_no_overflow", sts_overflow, 1'b0);
        check("pushpop_still_valid", m_axis_tvalid, 1'b1);
        drive('0, '0);

        for (int k = 0; k < 2000; k++) begin
            if (k % 64 == 0) begin
                twos = 1'($urandom_range(0, 1));
                swap = 1'($urandom_range(0, 1));
                cfg_decim = 16'($urandom_range(0, 3));
            end
            tready = ($urandom_range(0, 3) != 0);
            drive(PW'($urandom), PW'($urandom));
        end

        cfg_decim = 16'hFFFF; tready = 1'b1;
        repeat (8) drive('0, '0);
        check("drain_scoreboard", exp_q.size(), 0);
        check("drain_tvalid", m_axis_tvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
